// File: rtl/ins_loader.sv
// ins_loader: packs R-type fields into sequential instruction-memory writes.
// Define INS_LOADER_VERIFY_EN to add a readback compare after each write with a sticky err flag.
module ins_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FULL} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       word_q;
  logic              accept;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (clear) state_d = IDLE;
    else begin
      unique case (state_q)
        IDLE:    state_d = accept ? WRITE : IDLE;
`ifdef INS_LOADER_VERIFY_EN
        WRITE:   state_d = VERIFY;
        VERIFY:  state_d = (count_q == (ADDR_W+1)'(DEPTH)) ? FULL : IDLE;
`else
        WRITE:   state_d = (count_q + (ADDR_W+1)'(1) == (ADDR_W+1)'(DEPTH)) ? FULL : IDLE;
`endif
        default: state_d = FULL;
      endcase
    end
  end
  // clear blocks acceptance combinationally so a restart never races a new handshake
  always_comb begin
    in_ready = (state_q == IDLE) && !clear;
    mem_we   = state_q == WRITE;
    mem_addr = (state_q == VERIFY) ? ptr_q - ADDR_W'(1) : ptr_q;
    full     = state_q == FULL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      if (accept) word_q <= {6'b000000, rs, rt, rd, 5'b00000, funct};
      if (clear) begin
        ptr_q   <= '0;
        count_q <= '0;
      end else if (mem_we) begin
        ptr_q   <= ptr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W+1)'(1);
      end
    end
  end
  assign mem_data = word_q;
  assign count    = count_q;
`ifdef INS_LOADER_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == VERIFY && mem_rdata != word_q) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign err = 1'b0;
`endif
endmodule
